// File: rtl/vga_frame_capture.sv
// Receive side of the VGA output: recovers pixel position from HS/VS/BLANK, locks to the
// expected visible raster and writes decimated pixels into a frame buffer.
module vga_frame_capture #(
    parameter int    BITS_PER_COLOUR_CHANNEL = 4,
    parameter string MONOCHROME              = "FALSE",
    parameter string RESOLUTION              = "320x240",
    parameter int    C_HORZ_NUM_PIXELS       = 640,
    parameter int    C_VERT_NUM_PIXELS       = 480,
    localparam int   ADDR_W = (RESOLUTION == "160x120") ? 15 : 17,
    localparam int   DATA_W = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic              vga_clock,
    input  logic              resetn,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic              VGA_BLANK,
    input  logic [9:0]        VGA_R,
    input  logic [9:0]        VGA_G,
    input  logic [9:0]        VGA_B,
    output logic [ADDR_W-1:0] wr_address,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              locked,
    output logic              frame_done,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int              BPC_C        = BITS_PER_COLOUR_CHANNEL;
    localparam bit              QUARTER_C    = (RESOLUTION == "160x120");
    localparam bit              MONO_C       = (MONOCHROME == "TRUE");
    localparam int              DEC_SHIFT_C  = QUARTER_C ? 2 : 1;
    localparam logic [9:0]      DEC_MASK_C   = QUARTER_C ? 10'd3 : 10'd1;
    localparam logic [ADDR_W-1:0] LINE_WORDS_C = QUARTER_C ? ADDR_W'(32'd160) : ADDR_W'(32'd320);
    localparam logic [9:0]      H_NUM_C      = 10'(C_HORZ_NUM_PIXELS);
    localparam logic [9:0]      V_NUM_C      = 10'(C_VERT_NUM_PIXELS);
    localparam logic [9:0]      CNT_MAX_C    = 10'd1023;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == CNT_MAX_C) ? v : v + 10'd1;
    endfunction

    logic             hs_r, vs_r, blank_r, vs_d_r, blank_d_r;
    logic [BPC_C-1:0] red_r, green_r, blue_r;
    logic [9:0]       xpix_r, ypix_r;
    logic             vs_seen_r, frame_bad_r;
    state_t           state_r, next_state_s;

    logic              blank_rise_s, blank_fall_s, vs_fall_s;
    logic [9:0]        cur_x_s;
    logic              width_bad_s, count_bad_s, blank_vs_s, viol_s;
    logic              wr_go_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] pix_data_s;
    logic              unused_s;

    // Only the top bits of each colour bus are kept; the rest, and HS, are not needed.
    assign unused_s = ^{hs_r, VGA_R, VGA_G, VGA_B, red_r, green_r, blue_r};

    generate
        if (MONO_C) begin : g_mono
            assign pix_data_s = red_r[BPC_C-1];
        end else begin : g_rgb
            assign pix_data_s = {red_r, green_r, blue_r};
        end
    endgenerate

    // Input capture register plus delayed copies for edge detection.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            hs_r      <= 1'b0;
            vs_r      <= 1'b0;
            blank_r   <= 1'b0;
            vs_d_r    <= 1'b0;
            blank_d_r <= 1'b0;
            red_r     <= '0;
            green_r   <= '0;
            blue_r    <= '0;
        end else begin
            hs_r      <= VGA_HS;
            vs_r      <= VGA_VS;
            blank_r   <= VGA_BLANK;
            vs_d_r    <= vs_r;
            blank_d_r <= blank_r;
            red_r     <= VGA_R[9 -: BPC_C];
            green_r   <= VGA_G[9 -: BPC_C];
            blue_r    <= VGA_B[9 -: BPC_C];
        end
    end

    // Edge detection, timing checks and write decision for the pixel in the input register.
    always_comb begin
        blank_rise_s = blank_r & ~blank_d_r;
        blank_fall_s = ~blank_r & blank_d_r;
        vs_fall_s    = ~vs_r & vs_d_r;
        cur_x_s      = blank_rise_s ? 10'd0 : xpix_r;
        width_bad_s  = blank_fall_s && (xpix_r != H_NUM_C);
        count_bad_s  = vs_fall_s && vs_seen_r && (ypix_r != V_NUM_C);
        // Report visible video inside vsync once per entry, not every cycle.
        blank_vs_s   = (blank_r & ~vs_r) & ~(blank_d_r & ~vs_d_r);
        viol_s       = width_bad_s | count_bad_s | blank_vs_s;
        wr_go_s      = (state_r == ST_LOCKED) && blank_r && !viol_s
                       && ((cur_x_s & DEC_MASK_C) == 10'd0)
                       && ((ypix_r & DEC_MASK_C) == 10'd0);
        addr_s       = ADDR_W'(ypix_r >> DEC_SHIFT_C) * LINE_WORDS_C
                       + ADDR_W'(cur_x_s >> DEC_SHIFT_C);
    end

    // Lock state machine: next-state decision.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (vs_fall_s && !viol_s) begin
                    next_state_s = ST_MEASURE;
                end else begin
                    next_state_s = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (vs_fall_s && !viol_s && !frame_bad_r) begin
                    next_state_s = ST_LOCKED;
                end else begin
                    next_state_s = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if (viol_s) begin
                    next_state_s = ST_SEARCH;
                end else begin
                    next_state_s = ST_LOCKED;
                end
            end
            default: next_state_s = ST_SEARCH;
        endcase
    end

    // Lock state register and per-frame violation tracking.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_SEARCH;
            vs_seen_r   <= 1'b0;
            frame_bad_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (vs_fall_s) begin
                vs_seen_r   <= 1'b1;
                frame_bad_r <= 1'b0;
            end else if (viol_s) begin
                frame_bad_r <= 1'b1;
            end
        end
    end

    // Pixel and line position counters, saturating at 1023.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            xpix_r <= 10'd0;
            ypix_r <= 10'd0;
        end else begin
            if (blank_r) begin
                xpix_r <= sat_inc10(cur_x_s);
            end
            if (vs_fall_s) begin
                ypix_r <= 10'd0;
            end else if (blank_fall_s) begin
                ypix_r <= sat_inc10(ypix_r);
            end
        end
    end

    // Registered outputs: write port, lock status, frame and error pulses.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            wr_en      <= wr_go_s;
            if (wr_go_s) begin
                wr_address <= addr_s;
                wr_data    <= pix_data_s;
            end
            locked     <= (next_state_s == ST_LOCKED);
            frame_done <= (state_r == ST_LOCKED) && vs_fall_s && !viol_s;
            err        <= viol_s;
            if (viol_s && (err_count != 8'd255)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture on a reduced 16x8 raster (2x2 and 4x4 instances).
module tb_vga_frame_capture;

    localparam int H_VIS = 16;
    localparam int H_TOT = 24;
    localparam int V_VIS = 8;

    logic       vga_clock = 1'b0;
    logic       resetn    = 1'b0;
    logic       VGA_HS    = 1'b1;
    logic       VGA_VS    = 1'b1;
    logic       VGA_BLANK = 1'b0;
    logic [9:0] VGA_R     = 10'd0;
    logic [9:0] VGA_G     = 10'd0;
    logic [9:0] VGA_B     = 10'd0;

    logic [16:0] wr_address;
    logic [11:0] wr_data;
    logic        wr_en, locked, frame_done, err;
    logic [7:0]  err_count;
    logic [14:0] q_wr_address;
    logic [11:0] q_wr_data;
    logic        q_wr_en, q_locked, q_frame_done, q_err;
    logic [7:0]  q_err_count;

    vga_frame_capture #(.C_HORZ_NUM_PIXELS(H_VIS), .C_VERT_NUM_PIXELS(V_VIS)) dut (
        .vga_clock(vga_clock), .resetn(resetn), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK(VGA_BLANK), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en), .locked(locked),
        .frame_done(frame_done), .err(err), .err_count(err_count));

    vga_frame_capture #(.RESOLUTION("160x120"), .C_HORZ_NUM_PIXELS(H_VIS),
                        .C_VERT_NUM_PIXELS(V_VIS)) dut_q (
        .vga_clock(vga_clock), .resetn(resetn), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK(VGA_BLANK), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .wr_address(q_wr_address), .wr_data(q_wr_data), .wr_en(q_wr_en), .locked(q_locked),
        .frame_done(q_frame_done), .err(q_err), .err_count(q_err_count));

    always #5 vga_clock = ~vga_clock;

    typedef struct packed { logic [16:0] a; logic [11:0] d; } wr_t;
    typedef struct packed { logic [14:0] a; logic [11:0] d; } qwr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  sb_q[$];
    qwr_t qsb_q[$];
    logic [11:0] fb [int];
    logic [11:0] qfb [int];
    bit   exp_lock = 1'b0;
    int   n_wr = 0, n_qwr = 0, n_err = 0, n_fd = 0;
    int   lock_cyc = -1, vs_cyc = -1;
    logic locked_prev = 1'b0;
    logic [11:0] px02_exp = 12'd0;

    always @(posedge vga_clock) cyc <= cyc + 1;

    // Output monitor: pops the scoreboards on every write strobe and tallies pulses.
    always @(negedge vga_clock) begin : mon
        wr_t  e;
        qwr_t f;
        if (wr_en) begin
            n_wr++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h required no write", wr_address, wr_data);
            end else begin
                e = sb_q.pop_front();
                if (wr_address !== e.a || wr_data !== e.d) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                             wr_address, wr_data, e.a, e.d);
                end
            end
            fb[int'(wr_address)] = wr_data;
        end
        if (q_wr_en) begin
            n_qwr++;
            checks++;
            if (qsb_q.size() == 0) begin
                errors++;
                $display("FAIL q_unexpected_write got addr=%0d data=%h required no write", q_wr_address, q_wr_data);
            end else begin
                f = qsb_q.pop_front();
                if (q_wr_address !== f.a || q_wr_data !== f.d) begin
                    errors++;
                    $display("FAIL q_write got addr=%0d data=%h required addr=%0d data=%h",
                             q_wr_address, q_wr_data, f.a, f.d);
                end
            end
            qfb[int'(q_wr_address)] = q_wr_data;
        end
        if (err) n_err++;
        if (frame_done) n_fd++;
        if (locked && !locked_prev) lock_cyc = cyc;
        locked_prev = locked;
    end

    task automatic drive_cycle(input logic vs, input logic hs, input logic blank, input int x, input int y);
        logic [9:0] r, g, b;
        wr_t  e;
        qwr_t f;
        @(posedge vga_clock);
        #1;
        r = 10'($urandom);
        g = 10'($urandom);
        b = 10'($urandom);
        if (x == 2 && y == 0) begin
            r = 10'h3FF; g = 10'h000; b = 10'h000;
        end
        if (x == 4 && y == 4) begin
            r = 10'h000; g = 10'h2AA; b = 10'h000;
        end
        if (!blank) begin
            r = 10'd0; g = 10'd0; b = 10'd0;
        end
        if (!vs && VGA_VS) vs_cyc = cyc;
        VGA_VS = vs; VGA_HS = hs; VGA_BLANK = blank;
        VGA_R = r; VGA_G = g; VGA_B = b;
        if (blank && exp_lock) begin
            if (x % 2 == 0 && y % 2 == 0) begin
                e.a = 17'((y / 2) * 320 + x / 2);
                e.d = {r[9:6], g[9:6], b[9:6]};
                sb_q.push_back(e);
                if (x == 0 && y == 2) px02_exp = e.d;
            end
            if (x % 4 == 0 && y % 4 == 0) begin
                f.a = 15'((y / 4) * 160 + x / 4);
                f.d = {r[9:6], g[9:6], b[9:6]};
                qsb_q.push_back(f);
            end
        end
    endtask

    task automatic drive_line(input logic vs, input bit vis, input int nvis, input int y);
        for (int i = 0; i < H_TOT; i++) begin
            drive_cycle(vs, !(i >= 18 && i < 21), vis && (i < nvis), i, y);
        end
    endtask

    // One frame: vsync (2 lines), back porch, visible lines, front porch.
    task automatic drive_frame(input int nlines, input int bad_line);
        drive_line(1'b0, 1'b0, 0, 0);
        drive_line(1'b0, 1'b0, 0, 0);
        drive_line(1'b1, 1'b0, 0, 0);
        for (int y = 0; y < nlines; y++) begin
            drive_line(1'b1, 1'b1, (y == bad_line) ? H_VIS - 1 : H_VIS, y);
            if (y == bad_line) exp_lock = 1'b0;
        end
        drive_line(1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge vga_clock);
        #1;
        checks++;
        if ({wr_en, locked, frame_done, err, err_count, wr_address, wr_data} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b lk=%b fd=%b er=%b ec=%0d a=%0d d=%h required all 0",
                     wr_en, locked, frame_done, err, err_count, wr_address, wr_data);
        end
        checks++;
        if ({q_wr_en, q_locked, q_frame_done, q_err, q_err_count, q_wr_address, q_wr_data} !== 39'd0) begin
            errors++;
            $display("FAIL reset_q_outputs got lk=%b ec=%0d a=%0d required all 0", q_locked, q_err_count, q_wr_address);
        end
        resetn = 1'b1;
        repeat (3) @(posedge vga_clock);
    endtask

    task automatic test_lock;
        int wr0, q0, fd0;
        exp_lock = 1'b0;
        fd0 = n_fd;
        drive_frame(V_VIS, -1);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL measure_locked got %b required 0", locked);
        end
        exp_lock = 1'b1;
        wr0 = n_wr; q0 = n_qwr;
        drive_frame(V_VIS, -1);
        checks++;
        if (lock_cyc - vs_cyc !== 2) begin
            errors++; $display("FAIL lock_latency got %0d required 2", lock_cyc - vs_cyc);
        end
        checks++;
        if (n_fd - fd0 !== 0) begin
            errors++; $display("FAIL frame_done_unlocked got %0d required 0", n_fd - fd0);
        end
        checks++;
        if (n_wr - wr0 !== (H_VIS / 2) * (V_VIS / 2)) begin
            errors++; $display("FAIL writes_per_frame got %0d required %0d", n_wr - wr0, (H_VIS / 2) * (V_VIS / 2));
        end
        checks++;
        if (n_qwr - q0 !== (H_VIS / 4) * (V_VIS / 4)) begin
            errors++; $display("FAIL q_writes_per_frame got %0d required %0d", n_qwr - q0, (H_VIS / 4) * (V_VIS / 4));
        end
        fd0 = n_fd;
        drive_frame(V_VIS, -1);
        checks++;
        if (n_fd - fd0 !== 1 || locked !== 1'b1) begin
            errors++; $display("FAIL frame_done_locked got fd=%0d locked=%b required fd=1 locked=1", n_fd - fd0, locked);
        end
    endtask

    task automatic test_pixel_map;
        fb.delete();
        qfb.delete();
        exp_lock = 1'b1;
        drive_frame(V_VIS, -1);
        checks++;
        if (!fb.exists(1) || fb[1] !== 12'hF00) begin
            errors++; $display("FAIL pixel_2_0 got exists=%0d required addr 1 data f00", fb.exists(1));
        end
        checks++;
        if (!fb.exists(320) || fb[320] !== px02_exp) begin
            errors++; $display("FAIL pixel_0_2 got exists=%0d required addr 320 data %h", fb.exists(320), px02_exp);
        end
        checks++;
        if (!qfb.exists(161) || qfb[161] !== 12'h0A0) begin
            errors++; $display("FAIL q_pixel_4_4 got exists=%0d required addr 161 data 0a0", qfb.exists(161));
        end
    endtask

    task automatic test_bad_width;
        int e0, w0;
        e0 = n_err;
        exp_lock = 1'b1;
        drive_frame(V_VIS, 3);
        checks++;
        if (n_err - e0 !== 1 || err_count !== 8'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bad_width got errs=%0d ec=%0d locked=%b required 1 1 0", n_err - e0, err_count, locked);
        end
        exp_lock = 1'b0;
        drive_frame(V_VIS, -1);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL relock_early got %b required 0", locked);
        end
        exp_lock = 1'b1;
        w0 = n_wr;
        drive_frame(V_VIS, -1);
        checks++;
        if (locked !== 1'b1 || n_wr - w0 !== (H_VIS / 2) * (V_VIS / 2)) begin
            errors++; $display("FAIL relock got locked=%b writes=%0d required 1 %0d", locked, n_wr - w0, (H_VIS / 2) * (V_VIS / 2));
        end
    endtask

    task automatic test_short_frame;
        int e0;
        exp_lock = 1'b1;
        drive_frame(V_VIS - 1, -1);
        e0 = n_err;
        exp_lock = 1'b0;
        drive_frame(V_VIS, -1);
        checks++;
        if (n_err - e0 !== 1 || err_count !== 8'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL short_frame got errs=%0d ec=%0d locked=%b required 1 2 0", n_err - e0, err_count, locked);
        end
    endtask

    task automatic test_reset_mid;
        int e0;
        exp_lock = 1'b0;
        drive_frame(V_VIS, -1);
        exp_lock = 1'b1;
        drive_line(1'b0, 1'b0, 0, 0);
        drive_line(1'b0, 1'b0, 0, 0);
        drive_line(1'b1, 1'b0, 0, 0);
        for (int x = 0; x < 6; x++) drive_cycle(1'b1, 1'b1, 1'b1, x, 0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd2) begin
            errors++; $display("FAIL pre_reset got locked=%b ec=%0d required 1 2", locked, err_count);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({wr_en, locked, frame_done, err, err_count, wr_address, wr_data} !== 41'd0 ||
            {q_wr_en, q_locked, q_frame_done, q_err, q_err_count, q_wr_address, q_wr_data} !== 39'd0) begin
            errors++;
            $display("FAIL async_reset got lk=%b ec=%0d a=%0d q_a=%0d required all 0",
                     locked, err_count, wr_address, q_wr_address);
        end
        exp_lock = 1'b0;
        sb_q.delete();
        qsb_q.delete();
        VGA_BLANK = 1'b0; VGA_VS = 1'b1; VGA_HS = 1'b1;
        repeat (3) @(posedge vga_clock);
        #1;
        resetn = 1'b1;
        e0 = n_err;
        repeat (300) drive_line(1'b1, 1'b1, H_VIS - 1, 0);
        drive_line(1'b1, 1'b0, 0, 0);
        checks++;
        if (err_count !== 8'd255 || n_err - e0 !== 300 || locked !== 1'b0) begin
            errors++;
            $display("FAIL err_saturate got ec=%0d errs=%0d locked=%b required 255 300 0", err_count, n_err - e0, locked);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lock();
        test_pixel_map();
        test_bad_width();
        test_short_frame();
        test_reset_mid();
        repeat (4) @(posedge vga_clock);
        checks++;
        if (sb_q.size() != 0 || qsb_q.size() != 0) begin
            errors++; $display("FAIL pending_writes got %0d/%0d required 0/0", sb_q.size(), qsb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
